// File: rtl/matmul_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// matmul_seq_ctrl_if
//   Groups the start/busy/done handshake, the RAM A/B/C address and strobe
//   signals and the cycle counter readout for the matrix-multiply sequencer.
//
//   Parameters
//     AW : RAM address width
//     CW : cycle counter width
//
//   Signals
//     start        request a run (level, sampled only in IDLE or DONE)
//     busy         run in progress
//     done         run finished, held until next accepted start or reset
//     addr_a       RAM A read address
//     addr_b       RAM B read address
//     mac_clr      clear MAC accumulator
//     mac_en       MAC accumulate enable, aligned with RAM read data
//     addr_c       RAM C write address, valid while c_we=1
//     c_we         RAM C write strobe
//     clock_count  busy-cycle count of the last/current run
//
//   Modports
//     master : the sequencer (drives everything except start)
//     slave  : the requester / datapath side (drives start)
// ---------------------------------------------------------------------------
interface matmul_seq_ctrl_if #(
    parameter int AW = 8,
    parameter int CW = 11
);
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic          mac_clr;
    logic          mac_en;
    logic [AW-1:0] addr_c;
    logic          c_we;
    logic [CW-1:0] clock_count;

    modport master (
        input  start,
        output busy, done, addr_a, addr_b, mac_clr, mac_en, addr_c, c_we, clock_count
    );

    modport slave (
        output start,
        input  busy, done, addr_a, addr_b, mac_clr, mac_en, addr_c, c_we, clock_count
    );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// matmul_seq_ctrl
//   Sequencer for the matrix-multiply datapath (RAM A, RAM B, MAC, RAM C).
//   For every output element C[i][j] it clears the MAC, issues N reads
//   A[i][k] / B[k][j], waits out the RAM read latency, then writes C.
//   Elements are produced row-major (j fastest).
//
//   Parameters
//     N      : matrix dimension (NxN), 2..16
//     AW     : RAM address width, N*N <= 2**AW
//     RD_LAT : RAM read latency in cycles, 1..3
//     CW     : cycle counter width
//
//   Ports
//     clk    : system clock, rising edge
//     reset  : synchronous, active-high
//     bus    : handshake, RAM addresses/strobes, MAC controls, cycle count
//
//   Per element: CLEAR(1) + ACCUM(N) + DRAIN(RD_LAT) + WRITE(1) cycles.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | after reset, waiting for start
//   CLEAR  | mac_clr asserted for the element about to be computed
//   ACCUM  | issuing A/B reads, k = 0..N-1
//   DRAIN  | waiting RD_LAT cycles for the last read data to reach the MAC
//   WRITE  | c_we asserted, addr_c = i*N+j; advance j / i
//   DONE   | run complete, done held, waiting for start
// ---------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int N      = 8,
    parameter int AW     = 8,
    parameter int RD_LAT = 1,
    parameter int CW     = 11
) (
    input  logic               clk,
    input  logic               reset,
    matmul_seq_ctrl_if.master  bus
);

    localparam int             CTW        = $clog2(N) + 1;
    localparam logic [CTW-1:0] N_LAST     = CTW'(N - 1);
    localparam logic [1:0]     DRAIN_LAST = 2'(RD_LAT - 1);
    localparam logic [CW-1:0]  CC_MAX     = {CW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    logic [CTW-1:0]    i_cnt;
    logic [CTW-1:0]    j_cnt;
    logic [CTW-1:0]    k_cnt;
    logic [1:0]        drain_cnt;
    logic [RD_LAT-1:0] en_dly;
    logic [CW-1:0]     cyc_cnt;
    logic              busy_r;
    logic              done_r;
    logic              mac_clr_r;
    logic              c_we_r;
    logic [AW-1:0]     addr_a_r;
    logic [AW-1:0]     addr_b_r;
    logic [AW-1:0]     addr_c_r;

    // Row-major linear address row*N+col, truncated to the RAM width.
    function automatic logic [AW-1:0] lin(input logic [CTW-1:0] row,
                                          input logic [CTW-1:0] col);
        return AW'(32'(row) * 32'(N) + 32'(col));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            drain_cnt <= '0;
            en_dly    <= '0;
            cyc_cnt   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            mac_clr_r <= 1'b0;
            c_we_r    <= 1'b0;
            addr_a_r  <= '0;
            addr_b_r  <= '0;
            addr_c_r  <= '0;
        end else begin
            // Read data for an address issued in ACCUM reaches the MAC RD_LAT
            // cycles later; the line shifts in every state so it is always
            // empty by the time the next CLEAR comes round.
            en_dly[0] <= (state == S_ACCUM);
            for (int n = 1; n < RD_LAT; n++) begin
                en_dly[n] <= en_dly[n-1];
            end

            if (busy_r && (cyc_cnt != CC_MAX)) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end

            mac_clr_r <= 1'b0;
            c_we_r    <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state     <= S_CLEAR;
                        i_cnt     <= '0;
                        j_cnt     <= '0;
                        k_cnt     <= '0;
                        cyc_cnt   <= '0;
                        done_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        mac_clr_r <= 1'b1;
                    end
                end

                S_CLEAR: begin
                    state    <= S_ACCUM;
                    k_cnt    <= '0;
                    addr_a_r <= lin(i_cnt, '0);
                    addr_b_r <= lin('0, j_cnt);
                end

                S_ACCUM: begin
                    if (k_cnt == N_LAST) begin
                        // addresses hold their last value through DRAIN
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        k_cnt    <= k_cnt + 1'b1;
                        addr_a_r <= lin(i_cnt, k_cnt + 1'b1);
                        addr_b_r <= lin(k_cnt + 1'b1, j_cnt);
                    end
                end

                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state    <= S_WRITE;
                        c_we_r   <= 1'b1;
                        addr_c_r <= lin(i_cnt, j_cnt);
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end

                S_WRITE: begin
                    if ((i_cnt == N_LAST) && (j_cnt == N_LAST)) begin
                        state  <= S_DONE;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end else begin
                        state     <= S_CLEAR;
                        mac_clr_r <= 1'b1;
                        if (j_cnt == N_LAST) begin
                            j_cnt <= '0;
                            i_cnt <= i_cnt + 1'b1;
                        end else begin
                            j_cnt <= j_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.addr_a      = addr_a_r;
    assign bus.addr_b      = addr_b_r;
    assign bus.mac_clr     = mac_clr_r;
    assign bus.mac_en      = en_dly[RD_LAT-1];
    assign bus.addr_c      = addr_c_r;
    assign bus.c_we        = c_we_r;
    assign bus.clock_count = cyc_cnt;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matmul_seq_ctrl
//   Three sequencer instances driving behavioural RAM/MAC models:
//     0 : N=8, RD_LAT=1, CW=11 (defaults)
//     1 : N=2, RD_LAT=2, CW=11
//     2 : N=2, RD_LAT=1, CW=4  (cycle counter saturates)
//   Result matrices are compared against a plain A*B computed in the bench.
// ---------------------------------------------------------------------------
module tb_matmul_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;

    matmul_seq_ctrl_if #(.AW(8), .CW(11)) if0 ();
    matmul_seq_ctrl_if #(.AW(8), .CW(11)) if1 ();
    matmul_seq_ctrl_if #(.AW(8), .CW(4))  if2 ();

    matmul_seq_ctrl #(.N(8), .AW(8), .RD_LAT(1), .CW(11)) u_dut0 (.clk(clk), .reset(rst0), .bus(if0));
    matmul_seq_ctrl #(.N(2), .AW(8), .RD_LAT(2), .CW(11)) u_dut1 (.clk(clk), .reset(rst1), .bus(if1));
    matmul_seq_ctrl #(.N(2), .AW(8), .RD_LAT(1), .CW(4))  u_dut2 (.clk(clk), .reset(rst2), .bus(if2));

    int dim   [3] = '{8, 2, 2};
    int lat   [3] = '{1, 2, 1};
    int cc_max[3] = '{2047, 2047, 15};

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        busy, done, clr, en, we;
        logic [7:0]  a, b, c;
        logic [10:0] cc;
    } obs_t;

    function automatic obs_t obs(input int id);
        obs_t o;
        case (id)
            0: begin
                o.busy = if0.busy; o.done = if0.done; o.clr = if0.mac_clr; o.en = if0.mac_en;
                o.we = if0.c_we; o.a = if0.addr_a; o.b = if0.addr_b; o.c = if0.addr_c;
                o.cc = if0.clock_count;
            end
            1: begin
                o.busy = if1.busy; o.done = if1.done; o.clr = if1.mac_clr; o.en = if1.mac_en;
                o.we = if1.c_we; o.a = if1.addr_a; o.b = if1.addr_b; o.c = if1.addr_c;
                o.cc = if1.clock_count;
            end
            default: begin
                o.busy = if2.busy; o.done = if2.done; o.clr = if2.mac_clr; o.en = if2.mac_en;
                o.we = if2.c_we; o.a = if2.addr_a; o.b = if2.addr_b; o.c = if2.addr_c;
                o.cc = {7'b0, if2.clock_count};
            end
        endcase
        return o;
    endfunction

    task automatic set_start(input int id, input logic v);
        case (id)
            0: if0.start = v;
            1: if1.start = v;
            default: if2.start = v;
        endcase
    endtask

    task automatic set_rst(input int id, input logic v);
        case (id)
            0: rst0 = v;
            1: rst1 = v;
            default: rst2 = v;
        endcase
    endtask

    // ---------------- behavioural RAM / MAC model ----------------
    int     amem [3][256];
    int     bmem [3][256];
    int     cmem [3][256];
    int     ha   [3][4];
    int     hb   [3][4];
    longint acc  [3];
    int     we_cnt[3], en_cnt[3], clr_cnt[3], busy_cyc[3];
    bit     mon_on = 1'b0;

    task automatic mon(input int id);
        obs_t o;
        int   da, db;
        o  = obs(id);
        // RAM output this cycle is the word addressed lat cycles ago
        da = amem[id][ha[id][lat[id]-1]];
        db = bmem[id][hb[id][lat[id]-1]];
        if (o.clr || o.en) check_val("clr_en_exclusive", {63'b0, o.clr & o.en}, 64'd0);
        if (o.en)  check_val("en_while_busy", {63'b0, o.busy}, 64'd1);
        if (o.clr) begin
            acc[id] = 0;
            clr_cnt[id]++;
        end
        if (o.en) begin
            acc[id] += longint'(da) * longint'(db);
            en_cnt[id]++;
        end
        if (o.we) begin
            check_val("addr_c_order", 64'(o.c), 64'(we_cnt[id]));
            check_val("mac_en_per_elem", 64'(en_cnt[id]), 64'(dim[id]));
            check_val("mac_clr_per_elem", 64'(clr_cnt[id]), 64'd1);
            cmem[id][o.c] = int'(acc[id]);
            we_cnt[id]++;
            en_cnt[id]  = 0;
            clr_cnt[id] = 0;
        end
        if (o.busy) busy_cyc[id]++;
        for (int m = 3; m > 0; m--) begin
            ha[id][m] = ha[id][m-1];
            hb[id][m] = hb[id][m-1];
        end
        ha[id][0] = int'(o.a);
        hb[id][0] = int'(o.b);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            for (int id = 0; id < 3; id++) mon(id);
        end
    end

    task automatic prep(input int id);
        we_cnt[id]   = 0;
        en_cnt[id]   = 0;
        clr_cnt[id]  = 0;
        busy_cyc[id] = 0;
        for (int a = 0; a < 256; a++) cmem[id][a] = -1;
    endtask

    task automatic load_random(input int id);
        for (int a = 0; a < 256; a++) begin
            amem[id][a] = int'($urandom_range(0, 255));
            bmem[id][a] = int'($urandom_range(0, 255));
        end
    endtask

    // Counts rising edges until done is seen (sampled 2 time units after the
    // edge). glitch=0 leaves start alone; otherwise start is dropped after
    // the first edge and re-pulsed for one cycle at edge number 'glitch'.
    task automatic wait_done(input int id, input int glitch, output int cyc);
        cyc = 0;
        while (cyc < 20000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (glitch != 0) set_start(id, (cyc == glitch) ? 1'b1 : 1'b0);
            #1;
            if (obs(id).done === 1'b1) return;
        end
        check_val("done_timeout", 64'(cyc), 64'd0);
    endtask

    task automatic run_check(input int id, input int cyc, input int exp_lat);
        int     n, full, exp_cc;
        longint s;
        obs_t   o;
        n      = dim[id];
        full   = n * n * (n + lat[id] + 2);
        exp_cc = (full > cc_max[id]) ? cc_max[id] : full;
        o      = obs(id);
        check_val("done_latency", 64'(cyc), 64'(exp_lat));
        check_val("clock_count", 64'(o.cc), 64'(exp_cc));
        check_val("busy_low_in_done", {63'b0, o.busy}, 64'd0);
        check_val("write_count", 64'(we_cnt[id]), 64'(n * n));
        check_val("busy_cycles", 64'(busy_cyc[id]), 64'(full));
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++)
                    s += longint'(amem[id][i*n+k]) * longint'(bmem[id][k*n+j]);
                check_val("c_elem", 64'(cmem[id][i*n+j]), 64'(s));
            end
        end
    endtask

    task automatic pulse_run(input int id, input int glitch);
        int n, cyc;
        n = dim[id];
        prep(id);
        @(posedge clk);
        #1 set_start(id, 1'b1);
        wait_done(id, glitch, cyc);
        run_check(id, cyc, n * n * (n + lat[id] + 2) + 1);
    endtask

    initial begin
        int   cyc, r, guard;
        obs_t o;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
        for (int id = 0; id < 3; id++)
            for (int m = 0; m < 4; m++) begin ha[id][m] = 0; hb[id][m] = 0; end
        @(posedge clk);
        #1 mon_on = 1'b1;
        @(posedge clk);
        #1 begin rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; end

        // reset state after 10 idle cycles
        repeat (10) @(posedge clk);
        #2;
        o = obs(0);
        check_val("rst_busy", {63'b0, o.busy}, 64'd0);
        check_val("rst_done", {63'b0, o.done}, 64'd0);
        check_val("rst_mac_clr", {63'b0, o.clr}, 64'd0);
        check_val("rst_mac_en", {63'b0, o.en}, 64'd0);
        check_val("rst_c_we", {63'b0, o.we}, 64'd0);
        check_val("rst_addr_a", 64'(o.a), 64'd0);
        check_val("rst_addr_b", 64'(o.b), 64'd0);
        check_val("rst_addr_c", 64'(o.c), 64'd0);
        check_val("rst_clock_count", 64'(o.cc), 64'd0);
        for (int id = 1; id < 3; id++) begin
            o = obs(id);
            check_val("rst_outputs_small", {o.busy, o.done, o.clr, o.en, o.we, o.a, o.b, o.c, o.cc}, 64'd0);
        end

        // identity A, B[r][c] = r*8+c  ->  C = B
        for (int a = 0; a < 256; a++) begin
            amem[0][a] = ((a / 8) == (a % 8) && a < 64) ? 1 : 0;
            bmem[0][a] = a;
        end
        pulse_run(0, 100000);
        for (int a = 0; a < 64; a++) check_val("c_equals_b", 64'(cmem[0][a]), 64'(a));
        repeat (5) @(posedge clk);
        #2;
        o = obs(0);
        check_val("done_held", {63'b0, o.done}, 64'd1);
        check_val("count_frozen", 64'(o.cc), 64'd704);

        // random data, stray start at cycle 100 of the run
        load_random(0);
        pulse_run(0, 100);

        // small instances: RD_LAT=2, and saturating counter
        load_random(1);
        pulse_run(1, 100000);
        load_random(2);
        pulse_run(2, 100000);

        // reset somewhere in ACCUM of element 30
        load_random(0);
        prep(0);
        @(posedge clk);
        #1 set_start(0, 1'b1);
        @(posedge clk);
        #1 set_start(0, 1'b0);
        guard = 0;
        while (we_cnt[0] != 30 && guard < 2000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check_val("reached_elem30", 64'(we_cnt[0]), 64'd30);
        r = int'($urandom_range(1, 8));
        repeat (r) @(posedge clk);
        #1 set_rst(0, 1'b1);
        @(posedge clk);
        #1 set_rst(0, 1'b0);
        #1;
        o = obs(0);
        check_val("midrst_busy", {63'b0, o.busy}, 64'd0);
        check_val("midrst_c_we", {63'b0, o.we}, 64'd0);
        check_val("midrst_outputs", {o.busy, o.done, o.clr, o.en, o.we, o.a, o.b, o.c, o.cc}, 64'd0);
        repeat (10) @(posedge clk);
        #2;
        check_val("no_write_after_reset", 64'(we_cnt[0]), 64'd30);
        check_val("idle_after_reset", {63'b0, obs(0).busy}, 64'd0);
        pulse_run(0, 100000);

        // start held high across two runs
        load_random(0);
        prep(0);
        @(posedge clk);
        #1 set_start(0, 1'b1);
        wait_done(0, 0, cyc);
        run_check(0, cyc, 705);
        prep(0);
        @(posedge clk);
        #2;
        o = obs(0);
        check_val("held_done_one_cycle", {63'b0, o.done}, 64'd0);
        check_val("held_busy_again", {63'b0, o.busy}, 64'd1);
        check_val("held_count_restart", 64'(o.cc), 64'd0);
        wait_done(0, 0, cyc);
        set_start(0, 1'b0);
        run_check(0, cyc, 704);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Sequencer for the matrix-multiply datapath: RAM A, RAM B, the MAC and output RAM C.
- Walks i/j/k loop counters and generates A/B read addresses and the C write address.
- Drives MAC clear/enable aligned to RAM read latency.
- Provides start/busy/done handshake and a saturating cycle counter for the performance readout.

Parameters:
N, 8, matrix dimension (square NxN); 2..16
AW, 8, RAM address width; must satisfy N*N <= 2**AW
RD_LAT, 1, RAM read latency in cycles (address to data_out); 1..3
CW, 11, cycle counter width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
start  in  1  level, sampled only in IDLE or DONE
busy  out  1  high from the cycle after start is accepted through the final C write
done  out  1  high in DONE; held until next accepted start or reset
addr_a  out  AW  RAM A read address, A row-major: i*N+k
addr_b  out  AW  RAM B read address, B row-major: k*N+j
mac_clr  out  1  clear MAC accumulator (one cycle per output element)
mac_en  out  1  MAC accumulate enable, aligned with valid RAM data
addr_c  out  AW  RAM C write address: i*N+j
c_we  out  1  RAM C write strobe, one cycle per element
clock_count  out  CW  busy-cycle count of last/current run

Behaviour:
- Reset: state=IDLE.
  - All outputs 0: busy, done, mac_clr, mac_en, c_we, addr_a, addr_b, addr_c, clock_count.
  - i, j, k counters and mac_en delay line cleared.
- States: IDLE, CLEAR, ACCUM, DRAIN, WRITE, DONE.
- IDLE / DONE -> CLEAR when start=1. On that edge: i=j=k=0, clock_count=0, done=0, busy=1.
- CLEAR (1 cycle): mac_clr=1. Next state ACCUM, k=0.
- ACCUM (N cycles):
  - addr_a=i*N+k, addr_b=k*N+j; issue_valid=1; k increments.
  - After k=N-1: go to DRAIN, or to WRITE if RD_LAT=0 is ever allowed (not allowed, so always DRAIN).
- mac_en = issue_valid delayed by exactly RD_LAT cycles through a shift register. The delay line keeps shifting in every state.
- DRAIN (RD_LAT cycles): addr_a/addr_b hold last value; issue_valid=0.
- WRITE (1 cycle):
  - c_we=1, addr_c=i*N+j. Accumulator holds the full dot product because the MAC registers on the last mac_en edge.
  - Advance j; on j wrap (N-1 -> 0) advance i.
  - If i=N-1 and j=N-1: go to DONE; otherwise go to CLEAR.
- addr_c is valid only while c_we=1; otherwise it holds its previous value.
- DONE: done=1, busy=0. Outputs mac_clr, mac_en, c_we are 0. clock_count frozen.
- Per-element cost: N+RD_LAT+2 cycles. Full run: N*N*(N+RD_LAT+2) busy cycles. Defaults give 64*11 = 704.
- clock_count:
  - Increments every cycle busy=1, including the WRITE cycle of the last element.
  - Saturates at 2**CW-1; no wrap.
- Address arithmetic is unsigned, truncated to AW. i*N and k*N use counter widths of clog2(N)+1 bits.
- start while busy: ignored; no restart, no effect on counters.
- start held high continuously: run repeats, with DONE lasting exactly 1 cycle between runs.
- reset mid-run (any state): next cycle is IDLE with all outputs 0.
  - A partial C write is never issued after reset asserts; c_we=0 in the reset cycle's following state.
  - RAM C contents are untouched.
- mac_clr and mac_en never assert in the same cycle. Guaranteed because CLEAR follows DRAIN/WRITE, where the delay line is empty: WRITE occurs after RD_LAT drain cycles.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, state IDLE, clock_count=0.
- Defaults, A=identity, B[r][c]=r*8+c, pulse start 1 cycle:
  - 64 c_we pulses with addr_c 0..63 in order.
  - MAC model gives C=B.
  - done rises 705 cycles after the start edge; clock_count=704.
- N=2, RD_LAT=2:
  - Per element: 1 mac_clr, 2 mac_en exactly 2 cycles after addr_a/addr_b issue, then c_we.
  - Total clock_count=4*6=24.
- start pulsed at cycle 100 of a busy run -> no effect; completion time and clock_count identical to an uninterrupted run (704).
- reset asserted in ACCUM of element 30 -> next cycle IDLE, busy=0, c_we=0, no further writes. A fresh start completes normally with clock_count=704.
- start held high through two runs -> done high for exactly 1 cycle, clock_count restarts at 0, second run also reports 704.
